// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV M-extension multiply/divide unit.
//
// Computes one bit per cycle. Multiplication uses shift-add on operand
// magnitudes. Division is restoring, MSB first. The sign correction is folded
// into the register write on the final iteration, so no extra cycle is spent
// on it. Divide-by-zero and signed overflow bypass the iteration and finish
// one cycle after accept.
//
// Ports:
//   clk        clock, rising edge
//   rst_n      asynchronous active-low reset
//   flush      synchronous abort of any operation in flight
//   in_valid   request valid          in_ready  high only in IDLE
//   funct3     M-extension operation select
//   op_a       rs1 (multiplicand / dividend)
//   op_b       rs2 (multiplier / divisor)
//   rd_in      destination tag, returned unchanged on rd_out
//   out_valid  result valid           out_ready consumer accepts result
//   result     operation result       rd_out    tag of completed operation
//   busy       high in CALC or DONE
module muldiv_unit #(
    parameter int XLEN = 32,
    parameter int RD_W = 5,
    localparam int CNT_W = $clog2(XLEN) + 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    input  logic [RD_W-1:0] rd_in,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic [RD_W-1:0] rd_out,
    output logic            busy
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

    function automatic logic [XLEN-1:0] neg_if(input logic [XLEN-1:0] v, input logic n);
        return n ? (~v + 1'b1) : v;
    endfunction

    function automatic logic [2*XLEN-1:0] neg2_if(input logic [2*XLEN-1:0] v, input logic n);
        return n ? (~v + 1'b1) : v;
    endfunction

    state_t            state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [XLEN-1:0]   hi_q;       // product high half / partial remainder
    logic [XLEN-1:0]   lo_q;       // multiplier shifting out / dividend->quotient
    logic [XLEN-1:0]   opnd_q;     // multiplicand or divisor magnitude
    logic              is_div_q;
    logic              is_rem_q;
    logic              hi_sel_q;
    logic              neg_q;
    logic [RD_W-1:0]   rd_pend_q;
    logic [XLEN-1:0]   result_q;
    logic [RD_W-1:0]   rd_out_q;
    logic              out_valid_q;

    // Request decode, evaluated on the live inputs for the accept edge.
    logic            div_op, rem_op, a_signed, b_signed, sign_a, sign_b, neg_in;
    logic            special, hi_sel_in;
    logic [XLEN-1:0] a_mag, b_mag, special_res;

    always_comb begin
        div_op      = funct3[2];
        rem_op      = funct3[2] & funct3[1];
        hi_sel_in   = ~funct3[2] & (funct3[1:0] != 2'b00);
        if (div_op) begin
            a_signed = ~funct3[0];
            b_signed = ~funct3[0];
        end else begin
            a_signed = (funct3[1:0] == 2'b01) || (funct3[1:0] == 2'b10);
            b_signed = (funct3[1:0] == 2'b01);
        end
        sign_a      = a_signed & op_a[XLEN-1];
        sign_b      = b_signed & op_b[XLEN-1];
        neg_in      = rem_op ? sign_a : (sign_a ^ sign_b);
        a_mag       = neg_if(op_a, sign_a);
        b_mag       = neg_if(op_b, sign_b);
        special     = 1'b0;
        special_res = '0;
        if (div_op && (op_b == '0)) begin
            special     = 1'b1;
            special_res = funct3[1] ? op_a : '1;
        end else if (div_op && !funct3[0] && (op_a == MOST_NEG) && (op_b == '1)) begin
            special     = 1'b1;
            special_res = funct3[1] ? '0 : op_a;
        end
    end

    // One iteration of the active algorithm, plus the sign-corrected result
    // that is written when this iteration is the last.
    logic [XLEN:0]     mul_sum, div_shift, div_diff;
    logic [XLEN-1:0]   hi_d, lo_d, fin_d;
    logic [2*XLEN-1:0] prod_s;

    always_comb begin
        mul_sum   = {1'b0, hi_q} + {1'b0, (lo_q[0] ? opnd_q : {XLEN{1'b0}})};
        div_shift = {hi_q, lo_q[XLEN-1]};
        div_diff  = div_shift - {1'b0, opnd_q};
        if (is_div_q) begin
            // Borrow out of the trial subtraction means the divisor did not fit.
            hi_d = div_diff[XLEN] ? div_shift[XLEN-1:0] : div_diff[XLEN-1:0];
            lo_d = {lo_q[XLEN-2:0], ~div_diff[XLEN]};
        end else begin
            hi_d = mul_sum[XLEN:1];
            lo_d = {mul_sum[0], lo_q[XLEN-1:1]};
        end
        prod_s = neg2_if({hi_d, lo_d}, neg_q);
        if (is_div_q)
            fin_d = neg_if(is_rem_q ? hi_d : lo_d, neg_q);
        else
            fin_d = hi_sel_q ? prod_s[2*XLEN-1:XLEN] : prod_s[XLEN-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            hi_q        <= '0;
            lo_q        <= '0;
            opnd_q      <= '0;
            is_div_q    <= 1'b0;
            is_rem_q    <= 1'b0;
            hi_sel_q    <= 1'b0;
            neg_q       <= 1'b0;
            rd_pend_q   <= '0;
            result_q    <= '0;
            rd_out_q    <= '0;
            out_valid_q <= 1'b0;
        end else if (flush) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (in_valid) begin
                        is_div_q  <= div_op;
                        is_rem_q  <= rem_op;
                        hi_sel_q  <= hi_sel_in;
                        neg_q     <= neg_in;
                        rd_pend_q <= rd_in;
                        hi_q      <= '0;
                        lo_q      <= div_op ? a_mag : b_mag;
                        opnd_q    <= div_op ? b_mag : a_mag;
                        if (special) begin
                            result_q    <= special_res;
                            rd_out_q    <= rd_in;
                            out_valid_q <= 1'b1;
                            state_q     <= S_DONE;
                        end else begin
                            cnt_q   <= CNT_W'(XLEN);
                            state_q <= S_CALC;
                        end
                    end
                end
                S_CALC: begin
                    hi_q  <= hi_d;
                    lo_q  <= lo_d;
                    cnt_q <= cnt_q - 1'b1;
                    // Counter at 1 means this edge performs the last iteration.
                    if (cnt_q == CNT_W'(1)) begin
                        result_q    <= fin_d;
                        rd_out_q    <= rd_pend_q;
                        out_valid_q <= 1'b1;
                        state_q     <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= S_IDLE;
                    end
                end
                default: begin
                    out_valid_q <= 1'b0;
                    state_q     <= S_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign busy      = (state_q != S_IDLE);
    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign rd_out    = rd_out_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit at XLEN=32 and XLEN=16, checked against an
// arbitrary-precision arithmetic model of the M-extension operations.
module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        out_ready = 1'b1;
    logic [1:0]  in_valid = 2'b00;
    logic [2:0]  funct3 = 3'd0;
    logic [31:0] op_a = '0;
    logic [31:0] op_b = '0;
    logic [4:0]  rd_in = '0;

    logic        ir0, ov0, busy0, ir1, ov1, busy1;
    logic [31:0] res0;
    logic [15:0] res1;
    logic [4:0]  rdo0, rdo1;

    logic [1:0]  ov_v, ir_v, bz_v;
    logic [31:0] res_v [2];
    logic [4:0]  rd_v [2];

    assign ov_v = {ov1, ov0};
    assign ir_v = {ir1, ir0};
    assign bz_v = {busy1, busy0};
    assign res_v[0] = res0;
    assign res_v[1] = {16'h0, res1};
    assign rd_v[0] = rdo0;
    assign rd_v[1] = rdo1;

    always #5 clk = ~clk;

    muldiv_unit #(.XLEN(32), .RD_W(5)) u32 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid[0]), .in_ready(ir0),
        .funct3(funct3), .op_a(op_a), .op_b(op_b), .rd_in(rd_in), .out_valid(ov0),
        .out_ready(out_ready), .result(res0), .rd_out(rdo0), .busy(busy0)
    );

    muldiv_unit #(.XLEN(16), .RD_W(5)) u16 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid[1]), .in_ready(ir1),
        .funct3(funct3), .op_a(op_a[15:0]), .op_b(op_b[15:0]), .rd_in(rd_in), .out_valid(ov1),
        .out_ready(out_ready), .result(res1), .rd_out(rdo1), .busy(busy1)
    );

    int total = 0;
    int bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference: exact integer arithmetic on w-bit operands.
    function automatic logic [31:0] model(input int w, input logic [2:0] f3,
                                          input logic [31:0] a, input logic [31:0] b);
        logic signed [129:0] mask, au, bu, as_, bs, p;
        mask = (130'sd1 <<< w) - 130'sd1;
        au = '0; au[31:0] = a; au = au & mask;
        bu = '0; bu[31:0] = b; bu = bu & mask;
        as_ = au[w-1] ? au - (mask + 130'sd1) : au;
        bs  = bu[w-1] ? bu - (mask + 130'sd1) : bu;
        case (f3)
            3'd0: p = au * bu;
            3'd1: p = (as_ * bs) >>> w;
            3'd2: p = (as_ * bu) >>> w;
            3'd3: p = (au * bu) >>> w;
            3'd4: p = (bu == 0) ? mask : as_ / bs;
            3'd5: p = (bu == 0) ? mask : au / bu;
            3'd6: p = (bu == 0) ? au : as_ % bs;
            default: p = (bu == 0) ? au : au % bu;
        endcase
        return p[31:0] & mask[31:0];
    endfunction

    // Scoreboard: driver owns issued/dropped/exp_*, monitor owns cur/done/lat/seen.
    int          issued [2] = '{0, 0};
    int          dropped [2] = '{0, 0};
    int          cur [2] = '{0, 0};
    int          done [2] = '{0, 0};
    int          lat [2] = '{0, 0};
    bit          seen [2] = '{0, 0};
    logic [31:0] exp_res [2];
    logic [4:0]  exp_rd [2];
    int          exp_lat [2];

    initial begin
        forever begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                if (issued[i] != cur[i]) begin
                    cur[i] = issued[i];
                    lat[i] = 0;
                    seen[i] = 0;
                end
                if (cur[i] > done[i] && cur[i] > dropped[i]) begin
                    if (!seen[i]) begin
                        if (ov_v[i]) begin
                            chk("latency", lat[i], exp_lat[i]);
                            chk("result", res_v[i], exp_res[i]);
                            chk("rd_out", {27'd0, rd_v[i]}, {27'd0, exp_rd[i]});
                            seen[i] = 1;
                        end else begin
                            lat[i]++;
                        end
                    end else begin
                        chk("hold_valid", ov_v[i], 1);
                        chk("hold_result", res_v[i], exp_res[i]);
                        chk("hold_rd", {27'd0, rd_v[i]}, {27'd0, exp_rd[i]});
                        chk("hold_in_ready", ir_v[i], 0);
                        chk("hold_busy", bz_v[i], 1);
                    end
                    if (seen[i] && ov_v[i] && out_ready) done[i] = cur[i];
                end else if (ov_v[i]) begin
                    chk("spurious_valid", ov_v[i], 0);
                end
            end
        end
    end

    // Called at posedge+1; the request is accepted on the following edge.
    task automatic issue(input int i, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] rd, input logic [31:0] lit);
        int          w = (i != 0) ? 16 : 32;
        logic [31:0] mk = (i != 0) ? 32'h0000_FFFF : 32'hFFFF_FFFF;
        logic [31:0] mn = (i != 0) ? 32'h0000_8000 : 32'h8000_0000;
        logic [31:0] m = model(w, f3, a, b);
        logic        special = f3[2] && ((b == 0) || (!f3[0] && a == mn && b == mk));
        chk("model_pin", m, lit);
        chk("accept_ready", ir_v[i], 1);
        funct3 = f3; op_a = a; op_b = b; rd_in = rd;
        in_valid[i] = 1'b1;
        @(posedge clk); #1;
        in_valid[i] = 1'b0;
        // Scramble inputs after accept; the unit must have captured them.
        funct3 = 3'($urandom); op_a = $urandom; op_b = $urandom; rd_in = 5'($urandom);
        exp_res[i] = m;
        exp_rd[i] = rd;
        exp_lat[i] = special ? 0 : w;
        issued[i]++;
    endtask

    task automatic wait_retire(input int i);
        for (int k = 0; k < 200; k++) begin
            if (done[i] == issued[i]) break;
            @(posedge clk); #1;
        end
        chk("retired", 32'(done[i] == issued[i]), 1);
        if (done[i] != issued[i]) dropped[i] = issued[i];
    endtask

    logic [2:0]  tf3 [13] = '{3'd0, 3'd1, 3'd3, 3'd2, 3'd4, 3'd6, 3'd5, 3'd7, 3'd4, 3'd6, 3'd4, 3'd6, 3'd0};
    logic [31:0] ta32 [13] = '{32'd7, 32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFF9,
                               32'hFFFFFFF9, 32'd100, 32'd100, 32'd5, 32'd5, 32'h80000000,
                               32'h80000000, 32'd3};
    logic [31:0] tb32 [13] = '{32'hFFFFFFFD, 32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd2,
                               32'd2, 32'd7, 32'd7, 32'd0, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd4};
    logic [31:0] te32 [13] = '{32'hFFFFFFEB, 32'h40000000, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'hFFFFFFFD,
                               32'hFFFFFFFF, 32'd14, 32'd2, 32'hFFFFFFFF, 32'd5, 32'h80000000,
                               32'd0, 32'd12};
    logic [31:0] ta16 [13] = '{32'd7, 32'h8000, 32'hFFFF, 32'hFFFF, 32'hFFF9, 32'hFFF9, 32'd100,
                               32'd100, 32'd5, 32'd5, 32'h8000, 32'h8000, 32'd3};
    logic [31:0] tb16 [13] = '{32'hFFFD, 32'h8000, 32'hFFFF, 32'hFFFF, 32'd2, 32'd2, 32'd7, 32'd7,
                               32'd0, 32'd0, 32'hFFFF, 32'hFFFF, 32'd4};
    logic [31:0] te16 [13] = '{32'hFFEB, 32'h4000, 32'hFFFE, 32'hFFFF, 32'hFFFD, 32'hFFFF, 32'd14,
                               32'd2, 32'hFFFF, 32'd5, 32'h8000, 32'd0, 32'd12};

    initial begin
        #2;
        for (int i = 0; i < 2; i++) begin
            chk("rst_in_ready", ir_v[i], 1);
            chk("rst_out_valid", ov_v[i], 0);
            chk("rst_result", res_v[i], 0);
            chk("rst_rd_out", {27'd0, rd_v[i]}, 0);
            chk("rst_busy", bz_v[i], 0);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 2; i++) begin
            for (int k = 0; k < 13; k++) begin
                issue(i, tf3[k], (i != 0) ? ta16[k] : ta32[k], (i != 0) ? tb16[k] : tb32[k],
                      (k == 0) ? 5'd5 : 5'(k + 3), (i != 0) ? te16[k] : te32[k]);
                wait_retire(i);
            end
        end

        // Backpressure, then back-to-back request.
        out_ready = 1'b0;
        issue(0, 3'd0, 32'd3, 32'd4, 5'd9, 32'd12);
        for (int k = 0; k < 100; k++) begin
            if (ov0) break;
            @(posedge clk); #1;
        end
        chk("bp_valid", ov0, 1);
        repeat (10) begin
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_release_valid", ov0, 0);
        chk("bp_release_ready", ir0, 1);
        chk("bp_release_busy", busy0, 0);
        issue(0, 3'd5, 32'd100, 32'd7, 5'd17, 32'd14);
        chk("b2b_busy", busy0, 1);
        wait_retire(0);

        // Flush during CALC.
        issue(0, 3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd2, 32'hFFFFFFFE);
        repeat (9) begin
            @(posedge clk); #1;
        end
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        dropped[0] = issued[0];
        chk("flush_valid", ov0, 0);
        chk("flush_ready", ir0, 1);
        chk("flush_busy", busy0, 0);
        repeat (40) begin
            @(posedge clk); #1;
        end

        // Asynchronous reset during CALC; result still holds an earlier value.
        issue(0, 3'd1, 32'h80000000, 32'h80000000, 5'd21, 32'h40000000);
        repeat (5) begin
            @(posedge clk); #1;
        end
        rst_n = 1'b0;
        #1;
        chk("arst_valid", ov0, 0);
        chk("arst_result", res0, 0);
        chk("arst_rd", {27'd0, rdo0}, 0);
        chk("arst_busy", busy0, 0);
        chk("arst_ready", ir0, 1);
        dropped[0] = issued[0];
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        issue(0, 3'd0, 32'd3, 32'd4, 5'd30, 32'd12);
        wait_retire(0);
        issue(1, 3'd0, 32'd3, 32'd4, 5'd31, 32'd12);
        wait_retire(1);

        repeat (3) begin
            @(posedge clk); #1;
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
